// File: rtl/timer_pkg.sv
// Shared mode codes and FSM state encoding for the delay timer family.
package timer_pkg;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_RETRIG   = 2'd1;
    localparam logic [1:0] MODE_PERIODIC = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter_w.sv
// Loadable W-bit down counter; never wraps below 1 on decrement.
module down_counter_w #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         is_one
);

    // Count register: clear beats load beats decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count >= W'(2))) begin
            count <= count - W'(1);
        end
    end

    // Expiry is detected one count early so the reload path can take over.
    assign is_one = (count == W'(1));

endmodule

// File: rtl/delay_timer.sv
// Triggered delay timer with one-shot, retriggerable and periodic modes.
module delay_timer
    import timer_pkg::*;
#(
    parameter int unsigned W            = 16,
    parameter int unsigned MODE_DEFAULT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         trigger,
    input  logic         cancel,
    input  logic [W-1:0] N,
    input  logic [1:0]   mode,
    output logic         busy,
    output logic [W-1:0] remaining,
    output logic         time_out
);

    state_t     state, state_d;
    logic [1:0] mode_q, mode_d;
    logic       busy_d;
    logic       time_out_d;
    logic       cnt_load, cnt_en, cnt_clr;
    logic       cnt_is_one;
    logic       n_zero;
    logic [1:0] mode_default_unused;

    // Out of reset the mode always comes from the port at trigger time.
    assign mode_default_unused = 2'(MODE_DEFAULT);

    assign n_zero = (N == '0);

    down_counter_w #(.W(W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (N),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .count    (remaining),
        .is_one   (cnt_is_one)
    );

    // State, latched mode and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_ONESHOT;
            busy     <= 1'b0;
            time_out <= 1'b0;
        end else begin
            state    <= state_d;
            mode_q   <= mode_d;
            busy     <= busy_d;
            time_out <= time_out_d;
        end
    end

    // Next-state, counter control and output decode; cancel overrides all.
    always_comb begin
        state_d    = state;
        mode_d     = mode_q;
        busy_d     = busy;
        time_out_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;

        if (cancel) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger && !n_zero) begin
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                        mode_d   = mode;
                        cnt_load = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (trigger && (mode_q == MODE_RETRIG)) begin
                        // Restart suppresses any expiry due on this edge.
                        if (n_zero) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_load = 1'b1;
                        end
                    end else if (cnt_is_one) begin
                        time_out_d = 1'b1;
                        if ((mode_q == MODE_PERIODIC) && !n_zero) begin
                            cnt_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            cnt_clr = 1'b1;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_timer.sv
module tb_delay_timer;

    logic        clk;
    logic        rst_n;
    logic        trig16, canc16;
    logic [15:0] n16;
    logic [1:0]  mode16;
    logic        busy16, to16;
    logic [15:0] rem16;
    logic        trig4, canc4;
    logic [3:0]  n4;
    logic [1:0]  mode4;
    logic        busy4, to4;
    logic [3:0]  rem4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit busy;
        int rem;
        bit to;
        int md;
    } mdl_t;

    mdl_t m16, m4;

    delay_timer #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .trigger(trig16), .cancel(canc16),
        .N(n16), .mode(mode16), .busy(busy16), .remaining(rem16), .time_out(to16)
    );

    delay_timer #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .trigger(trig4), .cancel(canc4),
        .N(n4), .mode(mode4), .busy(busy4), .remaining(rem4), .time_out(to4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural timer: what one clock edge does to the visible outputs.
    function automatic mdl_t mdl_step(mdl_t s, bit trig, bit canc, int n, int m);
        mdl_t r;
        r = s;
        r.to = 1'b0;
        if (canc) begin
            r.busy = 0; r.rem = 0;
        end else if (!s.busy) begin
            if (trig && n != 0) begin
                r.busy = 1; r.rem = n; r.md = m;
            end
        end else if (trig && s.md == 1) begin
            if (n == 0) begin r.busy = 0; r.rem = 0; end
            else r.rem = n;
        end else if (s.rem == 1) begin
            r.to = 1;
            if (s.md == 2 && n != 0) r.rem = n;
            else begin r.busy = 0; r.rem = 0; end
        end else begin
            r.rem = s.rem - 1;
        end
        return r;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.busy = 0; r.rem = 0; r.to = 0; r.md = 0;
        return r;
    endfunction

    task automatic compare_all();
        check("busy16", int'(busy16), int'(m16.busy));
        check("rem16",  int'(rem16),  m16.rem);
        check("to16",   int'(to16),   int'(m16.to));
        check("busy4",  int'(busy4),  int'(m4.busy));
        check("rem4",   int'(rem4),   m4.rem);
        check("to4",    int'(to4),    int'(m4.to));
    endtask

    // One clock edge: advance the model with the inputs the DUT saw, then compare.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m16 = mdl_reset();
            m4  = mdl_reset();
        end else begin
            m16 = mdl_step(m16, trig16, canc16, int'(n16), int'(mode16));
            m4  = mdl_step(m4, trig4, canc4, int'(n4), int'(mode4));
        end
        #1;
        compare_all();
    endtask

    task automatic idle16();
        trig16 = 0; canc16 = 0;
    endtask

    initial begin
        int cnt;
        rst_n = 0;
        trig16 = 0; canc16 = 0; n16 = '0; mode16 = '0;
        trig4 = 0; canc4 = 0; n4 = '0; mode4 = '0;
        m16 = mdl_reset();
        m4  = mdl_reset();

        // Reset values
        #12;
        check("rst_busy", int'(busy16), 0);
        check("rst_rem",  int'(rem16),  0);
        check("rst_to",   int'(to16),   0);
        rst_n = 1;
        tick();

        // ONESHOT N=5
        trig16 = 1; n16 = 16'd5; mode16 = 2'd0;
        tick();
        check("os_rem_start", int'(rem16), 5);
        check("os_busy_start", int'(busy16), 1);
        idle16();
        for (int j = 1; j <= 4; j++) begin
            tick();
            check("os_rem", int'(rem16), 5 - j);
            check("os_to_early", int'(to16), 0);
        end
        tick();
        check("os_to", int'(to16), 1);
        check("os_busy_end", int'(busy16), 0);
        tick();
        check("os_to_once", int'(to16), 0);

        // RETRIGGER N=8, retrigger at edge 5
        trig16 = 1; n16 = 16'd8; mode16 = 2'd1;
        tick();
        idle16();
        for (int e = 1; e <= 4; e++) tick();
        trig16 = 1;
        tick();
        check("rt_reload", int'(rem16), 8);
        idle16();
        for (int e = 6; e <= 12; e++) begin
            tick();
            check("rt_no_to", int'(to16), 0);
        end
        tick();
        check("rt_to13", int'(to16), 1);
        tick();

        // PERIODIC N=4, cancel at edge 14
        trig16 = 1; n16 = 16'd4; mode16 = 2'd2;
        tick();
        idle16();
        for (int e = 1; e <= 16; e++) begin
            canc16 = (e == 14);
            tick();
            check("per_to", int'(to16), int'(e == 4 || e == 8 || e == 12));
            if (e >= 14) check("per_busy_off", int'(busy16), 0);
        end
        idle16();

        // N=0 trigger ignored
        trig16 = 1; n16 = '0; mode16 = 2'd0;
        tick();
        check("n0_busy", int'(busy16), 0);
        idle16();
        tick();
        check("n0_to", int'(to16), 0);

        // ONESHOT N=1
        trig16 = 1; n16 = 16'd1; mode16 = 2'd0;
        tick();
        check("n1_busy", int'(busy16), 1);
        check("n1_to_first", int'(to16), 0);
        idle16();
        tick();
        check("n1_to", int'(to16), 1);
        check("n1_busy_end", int'(busy16), 0);

        // Cancel and trigger together
        trig16 = 1; canc16 = 1; n16 = 16'd6;
        tick();
        check("ct_busy", int'(busy16), 0);
        idle16();
        tick();

        // Cancel on the expiry edge
        trig16 = 1; n16 = 16'd3; mode16 = 2'd0;
        tick();
        idle16();
        tick(); tick();
        canc16 = 1;
        tick();
        check("cx_to", int'(to16), 0);
        check("cx_rem", int'(rem16), 0);
        idle16();
        tick();
        check("cx_to_after", int'(to16), 0);

        // W=4, N=15, asynchronous reset mid-count
        trig4 = 1; n4 = 4'd15; mode4 = 2'd0;
        tick();
        trig4 = 0;
        for (int e = 1; e <= 6; e++) tick();
        check("w4_rem_mid", int'(rem4), 9);
        #2 rst_n = 0;
        #1;
        check("ar_busy", int'(busy4), 0);
        check("ar_rem",  int'(rem4),  0);
        check("ar_to",   int'(to4),   0);
        m16 = mdl_reset();
        m4  = mdl_reset();
        tick(); tick();
        rst_n = 1;
        for (int e = 0; e < 20; e++) begin
            tick();
            check("ar_quiet", int'(to4), 0);
        end
        trig4 = 1; n4 = 4'd15;
        tick();
        trig4 = 0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!to4 && cnt < 40);
        check("w4_full_count", cnt, 15);
        tick();

        // Randomized traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            trig16 = ($urandom_range(3) == 0);
            canc16 = ($urandom_range(24) == 0);
            n16    = 16'($urandom_range(6));
            mode16 = 2'($urandom_range(3));
            trig4  = ($urandom_range(4) == 0);
            canc4  = ($urandom_range(29) == 0);
            n4     = 4'($urandom_range(7));
            mode4  = 2'($urandom_range(3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
